rv32i_decode_stage: RTL

- Pipelined instruction decode stage between fetch and execute.
- Accepts a fetched {pc, instr} over a valid/ready handshake and decodes opcode, register indices, immediate and ALU operation.
- Presents the result to execute through a registered valid/ready interface.
- Contains a 2-entry skid buffer, so in_ready is a registered signal with no combinational path from out_ready.

---
 rtl/rv32i_decode_stage.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/rv32i_decode_stage.sv
// RV32I decode stage: {pc, instr} in, decoded fields out one cycle later through a 2-entry skid buffer.
// in_ready is registered (no path from out_ready); define DECODE_ILLEGAL_CNT_EN to add the illegal_cnt output.
module rv32i_decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [XLEN-1:0] out_imm,
    output logic [5:0]      out_alu_op,
    output logic            out_illegal
`ifdef DECODE_ILLEGAL_CNT_EN
    ,
    output logic [15:0]     illegal_cnt
`endif
);
    localparam logic [5:0] ALU_ADD = 6'd0, ALU_SUB = 6'd1, ALU_SLL = 6'd2, ALU_SLT = 6'd3,
                           ALU_SLTU = 6'd4, ALU_XOR = 6'd5, ALU_SRL = 6'd6, ALU_SRA = 6'd7,
                           ALU_OR = 6'd8, ALU_AND = 6'd9, ALU_ADDI = 6'd10, ALU_SLTI = 6'd11,
                           ALU_SLTIU = 6'd12, ALU_XORI = 6'd13, ALU_ORI = 6'd14, ALU_ANDI = 6'd15,
                           ALU_BYPASS = 6'd16, ALU_JALR = 6'd17, ALU_INVALID = 6'd18;

    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011,
                           OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011;

    localparam logic [6:0] F7_ZERO = 7'b0000000, F7_ALT = 7'b0100000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
        logic [5:0]      alu_op;
        logic            illegal;
    } dec_t;

    localparam dec_t DEC_RESET = '{pc: '0, opcode: '0, funct3: '0, rd: '0, rs1: '0, rs2: '0,
                                   imm: '0, alu_op: ALU_INVALID, illegal: 1'b0};

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [5:0]      w_alu_op;
    logic [XLEN-1:0] w_imm_sel;
    logic            w_illegal;
    dec_t            w_dec;
    logic            w_in_xfer;

    dec_t            r_main, r_skid;
    logic            r_main_vld, r_skid_vld, r_in_rdy;

    assign w_opcode = in_instr[6:0];
    assign w_funct3 = in_instr[14:12];
    assign w_funct7 = in_instr[31:25];

    assign w_imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign w_imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign w_imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign w_imm_u = {in_instr[31:12], 12'b0};
    assign w_imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

    always_comb begin
        w_alu_op  = ALU_INVALID;
        w_imm_sel = '0;
        case (w_opcode)
            OP_LUI:    begin w_alu_op = ALU_BYPASS; w_imm_sel = w_imm_u; end
            OP_AUIPC:  begin w_alu_op = ALU_ADD;    w_imm_sel = w_imm_u; end
            OP_JAL:    begin w_alu_op = ALU_BYPASS; w_imm_sel = w_imm_j; end
            OP_JALR:   if (w_funct3 == 3'b000) begin w_alu_op = ALU_JALR; w_imm_sel = w_imm_i; end
            OP_BRANCH: if (w_funct3 != 3'b010 && w_funct3 != 3'b011) begin
                           w_alu_op = ALU_SUB; w_imm_sel = w_imm_b;
                       end
            OP_LOAD:   if (w_funct3 == 3'b010) begin w_alu_op = ALU_ADD; w_imm_sel = w_imm_i; end
            OP_STORE:  if (w_funct3 == 3'b010) begin w_alu_op = ALU_ADD; w_imm_sel = w_imm_s; end
            OP_IMM: begin
                w_imm_sel = w_imm_i;
                case (w_funct3)
                    3'b000: w_alu_op = ALU_ADDI;
                    3'b010: w_alu_op = ALU_SLTI;
                    3'b011: w_alu_op = ALU_SLTIU;
                    3'b100: w_alu_op = ALU_XORI;
                    3'b110: w_alu_op = ALU_ORI;
                    3'b111: w_alu_op = ALU_ANDI;
                    3'b001: if (w_funct7 == F7_ZERO) w_alu_op = ALU_SLL;
                    default: begin
                        if (w_funct7 == F7_ZERO)     w_alu_op = ALU_SRL;
                        else if (w_funct7 == F7_ALT) w_alu_op = ALU_SRA;
                    end
                endcase
            end
            OP_REG: begin
                if (w_funct7 == F7_ZERO) begin
                    case (w_funct3)
                        3'b000:  w_alu_op = ALU_ADD;
                        3'b001:  w_alu_op = ALU_SLL;
                        3'b010:  w_alu_op = ALU_SLT;
                        3'b011:  w_alu_op = ALU_SLTU;
                        3'b100:  w_alu_op = ALU_XOR;
                        3'b101:  w_alu_op = ALU_SRL;
                        3'b110:  w_alu_op = ALU_OR;
                        default: w_alu_op = ALU_AND;
                    endcase
                end else if (w_funct7 == F7_ALT) begin
                    if (w_funct3 == 3'b000)      w_alu_op = ALU_SUB;
                    else if (w_funct3 == 3'b101) w_alu_op = ALU_SRA;
                end
            end
            default: ;
        endcase
    end

    // Every illegal path leaves alu_op at INVALID, so legality falls out of the op itself.
    assign w_illegal = (w_alu_op == ALU_INVALID);

    always_comb begin
        w_dec         = DEC_RESET;
        w_dec.pc      = in_pc;
        w_dec.opcode  = w_opcode;
        w_dec.funct3  = w_funct3;
        w_dec.rd      = in_instr[11:7];
        w_dec.rs1     = in_instr[19:15];
        w_dec.rs2     = in_instr[24:20];
        w_dec.imm     = w_illegal ? '0 : w_imm_sel;
        w_dec.alu_op  = w_alu_op;
        w_dec.illegal = w_illegal;
    end

    assign w_in_xfer = in_valid && r_in_rdy;

    // Skid only fills while main is stalled; it always empties into main first, preserving order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main     <= DEC_RESET;
            r_skid     <= DEC_RESET;
            r_main_vld <= 1'b0;
            r_skid_vld <= 1'b0;
            r_in_rdy   <= 1'b0;
        end else if (flush) begin
            r_main_vld <= 1'b0;
            r_skid_vld <= 1'b0;
            r_in_rdy   <= 1'b1;
        end else if (!r_main_vld || out_ready) begin
            if (r_skid_vld) begin
                r_main     <= r_skid;
                r_main_vld <= 1'b1;
                r_skid_vld <= 1'b0;
            end else begin
                r_main_vld <= w_in_xfer;
                if (w_in_xfer) r_main <= w_dec;
            end
            r_in_rdy <= 1'b1;
        end else if (w_in_xfer) begin
            r_skid     <= w_dec;
            r_skid_vld <= 1'b1;
            r_in_rdy   <= 1'b0;
        end
    end

    assign in_ready    = r_in_rdy;
    assign out_valid   = r_main_vld;
    assign out_pc      = r_main.pc;
    assign out_opcode  = r_main.opcode;
    assign out_funct3  = r_main.funct3;
    assign out_rd      = r_main.rd;
    assign out_rs1     = r_main.rs1;
    assign out_rs2     = r_main.rs2;
    assign out_imm     = r_main.imm;
    assign out_alu_op  = r_main.alu_op;
    assign out_illegal = r_main.illegal;

`ifdef DECODE_ILLEGAL_CNT_EN
    logic [15:0] r_illegal_cnt;

    // Counts consumed illegal instructions, including one consumed in the same cycle as a flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_illegal_cnt <= '0;
        end else if (r_main_vld && out_ready && r_main.illegal && r_illegal_cnt != 16'hFFFF) begin
            r_illegal_cnt <= r_illegal_cnt + 16'd1;
        end
    end

    assign illegal_cnt = r_illegal_cnt;
`endif

endmodule
